// File: rtl/mem_pkg.sv
// Shared memory-path definitions: store-buffer depth, byte-enable patterns
// and the layout of one buffered store entry.
package mem_pkg;

    localparam int SB_DEPTH = 4;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int PC_W   = 32;

    localparam logic [BE_W-1:0] BE_WORD  = 4'b1111;
    localparam logic [BE_W-1:0] BE_HALF0 = 4'b0011;
    localparam logic [BE_W-1:0] BE_HALF1 = 4'b1100;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic [PC_W-1:0]   pc;
    } sb_entry_t;

endpackage

// File: rtl/dm_store_buffer_fifo.sv
// In-order circular store FIFO with a per-entry word-address compare
// against the current load address.
module sb_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  sb_entry_t         push_entry,
    input  logic              pop,
    input  logic [29:0]       match_word,
    output sb_entry_t         head,
    output logic              full,
    output logic              empty,
    output logic [DEPTH-1:0]  match_vec
);

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] offset;

    // Entry payloads need no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        match_vec = '0;
        offset    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr;
            if (({1'b0, offset} < count) && (entries[i].addr[31:2] == match_word)) begin
                match_vec[i] = 1'b1;
            end
        end
    end

    assign head  = entries[rd_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/dm_store_buffer.sv
// Store buffer owning the single DM port: loads take the port first, queued
// stores drain in order whenever no non-conflicting load is present.
module dm_store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic [3:0]  st_be,
    input  logic [31:0] st_pc,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        stall,
    output logic        empty,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_pc
);

    sb_entry_t          push_entry;
    sb_entry_t          head;
    logic               full;
    logic               push;
    logic               drain;
    logic               ld_hit;
    logic [DEPTH-1:0]   match_vec;

    assign push_entry = '{addr: st_addr, wdata: st_wdata, be: st_be, pc: st_pc};

    sb_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .match_word (ld_addr[31:2]),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .match_vec  (match_vec)
    );

    // A conflicting load yields the port so the store it waits on can retire.
    assign ld_hit = ld_valid && (|match_vec);
    assign stall  = (st_valid && full) || ld_hit;
    assign push   = st_valid && !full;
    assign drain  = !empty && (!ld_valid || ld_hit);

    always_comb begin
        dm_we   = 1'b0;
        dm_addr = ld_addr;
        dm_wd   = '0;
        dm_be   = '0;
        dm_pc   = '0;
        if (drain) begin
            dm_we   = 1'b1;
            dm_addr = head.addr;
            dm_wd   = head.wdata;
            dm_be   = head.be;
            dm_pc   = head.pc;
        end
    end

endmodule
